otp_pgm_verify_ctrl: RTL and testbench



---
 rtl/otp_pgm_verify_ctrl_pkg.sv | 41 ++++
 rtl/otp_pgm_verify_ctrl_timer.sv | 49 ++++
 rtl/otp_pgm_verify_ctrl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_otp_pgm_verify_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otp_pgm_verify_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// otp_pkg
// Shared definitions for the OTP program/verify controller: command opcodes,
// response status codes, FSM state encodings and a small constant helper.
// ---------------------------------------------------------------------------
package otp_pkg;

  // Command opcodes as presented on cmd_op.
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_READ    = 2'b01,
    OP_PROGRAM = 2'b10,
    OP_BLANK   = 2'b11
  } op_e;

  // Response status codes as returned on rsp_status.
  typedef enum logic [1:0] {
    STS_OK        = 2'b00,
    STS_VFY_FAIL  = 2'b01,
    STS_NOT_BLANK = 2'b10,
    STS_BAD_COL   = 2'b11
  } status_e;

  // Controller states. Kept as plain constants so the encoding stays
  // stable for older blocks that decode the state directly.
  typedef logic [2:0] state_t;

  localparam state_t S_IDLE        = 3'd0;
  localparam state_t S_RD_SETTLE   = 3'd1;
  localparam state_t S_PGM_SETUP   = 3'd2;
  localparam state_t S_PGM_PULSE   = 3'd3;
  localparam state_t S_PGM_RECOVER = 3'd4;
  localparam state_t S_VFY_SETTLE  = 3'd5;
  localparam state_t S_DONE        = 3'd6;

  // Larger of two integers, used to size the shared phase timer.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/otp_pgm_verify_ctrl_timer.sv
// ---------------------------------------------------------------------------
// otp_timer
// Loadable down-counter used to time the sense-settle and program-pulse
// phases of the OTP controller. A single instance is shared by all phases.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   start     in   load load_val on this edge
//   load_val  in   phase length in cycles (>= 1)
//   done      out  high during the last cycle of the loaded phase
// ---------------------------------------------------------------------------
module otp_timer
  import otp_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // The count equals the number of cycles left in the phase, so the phase's
  // first cycle sees load_val and its last cycle sees 1. It rests at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/otp_pgm_verify_ctrl.sv
// ---------------------------------------------------------------------------
// otp_pgm_verify_ctrl
// OTP array controller. Accepts read, program and blank-check commands on a
// valid/ready interface, sequences the macro's wordline, bitline and program
// strobes, and runs a program / verify / retry loop that only pulses bits
// still needing a 0->1 transition. Returns data and status per command.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   cmd_valid     command request
//   cmd_ready     out: high only while idle
//   cmd_op        00 nop, 01 read, 10 program, 11 blank-check
//   cmd_col       target column
//   cmd_data      bits to program (1 = blow)
//   sense_data    sense-amp outputs from the macro
//   pl            program lines; pl[2c] precharge, pl[2c+1] HV strobe
//   bl            read bitline select
//   wln / wlp     read / program wordlines
//   prg           HV pump enable
//   read_active   sense window active
//   rsp_valid     one-cycle response pulse
//   rsp_data      column contents after the operation
//   rsp_status    00 ok, 01 verify fail, 10 not blank, 11 bad column
//   busy          high whenever not idle
// ---------------------------------------------------------------------------
module otp_pgm_verify_ctrl
  import otp_pkg::*;
#(
  parameter  int ROWS            = 8,
  parameter  int COLS            = 16,
  parameter  int PGM_PULSE_CYC   = 10,
  parameter  int READ_SETTLE_CYC = 4,
  parameter  int MAX_RETRY       = 3,
  localparam int ADDR_W          = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_col,
  input  logic [ROWS-1:0]   cmd_data,
  input  logic [ROWS-1:0]   sense_data,
  output logic [2*COLS-1:0] pl,
  output logic [COLS-1:0]   bl,
  output logic [ROWS-1:0]   wln,
  output logic [ROWS-1:0]   wlp,
  output logic              prg,
  output logic              read_active,
  output logic              rsp_valid,
  output logic [ROWS-1:0]   rsp_data,
  output logic [1:0]        rsp_status,
  output logic              busy
);

  localparam int TMR_MAX = max2(PGM_PULSE_CYC, READ_SETTLE_CYC);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [ADDR_W:0]  COLS_LIM  = (ADDR_W + 1)'(COLS);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(READ_SETTLE_CYC);
  localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(PGM_PULSE_CYC);
  localparam logic [RTY_W-1:0] RTY_LIM   = RTY_W'(MAX_RETRY);

  // Control state
  state_t            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ROWS-1:0]   mask_q, mask_d;
  logic [RTY_W-1:0]  retry_q, retry_d;

  // Registered outputs
  logic              cmd_ready_q, cmd_ready_d;
  logic [2*COLS-1:0] pl_q, pl_d;
  logic [COLS-1:0]   bl_q, bl_d;
  logic [ROWS-1:0]   wln_q, wln_d;
  logic [ROWS-1:0]   wlp_q, wlp_d;
  logic              prg_q, prg_d;
  logic              read_active_q, read_active_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ROWS-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic              busy_q, busy_d;

  // Timer interface and helpers
  logic              tmr_start;
  logic [TMR_W-1:0]  tmr_load;
  logic              tmr_done;
  logic              accept;
  logic              col_bad;
  logic [ROWS-1:0]   remaining;

  assign accept  = cmd_valid && cmd_ready_q;
  assign col_bad = ({1'b0, cmd_col} >= COLS_LIM);

  // Bits of the current mask that the macro still reads as 0. At the end of
  // the pre-read the mask holds cmd_data, so this yields cmd_data & ~sample;
  // at the end of a verify it yields the bits the last pulse failed to blow.
  assign remaining = mask_q & ~sense_data;

  otp_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (tmr_start),
    .load_val (tmr_load),
    .done     (tmr_done)
  );

  // Next-state logic. Timed phases load the shared timer on the edge that
  // enters them and leave on the cycle the timer reports done; sense_data
  // is captured on that same final settle cycle.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    col_d        = col_q;
    mask_d       = mask_q;
    retry_d      = retry_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    tmr_start    = 1'b0;
    tmr_load     = SETTLE_LD;

    case (state_q)
      S_IDLE: begin
        if (accept && (op_e'(cmd_op) != OP_NOP)) begin
          op_d    = op_e'(cmd_op);
          retry_d = '0;
          if (col_bad) begin
            col_d        = '0;
            state_d      = S_DONE;
            rsp_status_d = STS_BAD_COL;
            rsp_data_d   = '0;
          end else begin
            col_d     = cmd_col;
            mask_d    = cmd_data;
            state_d   = S_RD_SETTLE;
            tmr_start = 1'b1;
          end
        end
      end

      S_RD_SETTLE: begin
        if (tmr_done) begin
          rsp_data_d   = sense_data;
          rsp_status_d = STS_OK;
          state_d      = S_DONE;
          case (op_q)
            OP_BLANK: begin
              if (sense_data != '0) begin
                rsp_status_d = STS_NOT_BLANK;
              end
            end
            OP_PROGRAM: begin
              // Already-blown bits are dropped; nothing left means the
              // reprogram is a no-op and completes without a pulse.
              if (remaining != '0) begin
                mask_d  = remaining;
                state_d = S_PGM_SETUP;
              end
            end
            default: ;
          endcase
        end
      end

      S_PGM_SETUP: begin
        state_d   = S_PGM_PULSE;
        tmr_start = 1'b1;
        tmr_load  = PULSE_LD;
      end

      S_PGM_PULSE: begin
        if (tmr_done) begin
          state_d = S_PGM_RECOVER;
        end
      end

      S_PGM_RECOVER: begin
        state_d   = S_VFY_SETTLE;
        tmr_start = 1'b1;
      end

      S_VFY_SETTLE: begin
        if (tmr_done) begin
          rsp_data_d = sense_data;
          if (remaining == '0) begin
            rsp_status_d = STS_OK;
            state_d      = S_DONE;
          end else if (retry_q < RTY_LIM) begin
            retry_d = retry_q + RTY_W'(1);
            mask_d  = remaining;
            state_d = S_PGM_SETUP;
          end else begin
            rsp_status_d = STS_VFY_FAIL;
            state_d      = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so every strobe is a flop that
  // changes on the same edge as the state it belongs to.
  always_comb begin
    cmd_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    rsp_valid_d   = (state_d == S_DONE);
    pl_d          = '0;
    bl_d          = '0;
    wln_d         = '0;
    wlp_d         = '0;
    prg_d         = 1'b0;
    read_active_d = 1'b0;

    case (state_d)
      S_RD_SETTLE, S_VFY_SETTLE: begin
        bl_d[col_d]   = 1'b1;
        wln_d         = '1;
        read_active_d = 1'b1;
      end
      S_PGM_SETUP: begin
        pl_d[{col_d, 1'b0}] = 1'b1;
        prg_d               = 1'b1;
      end
      S_PGM_PULSE: begin
        pl_d[{col_d, 1'b0}] = 1'b1;
        pl_d[{col_d, 1'b1}] = 1'b1;
        wlp_d               = mask_d;
        prg_d               = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers. Reset aborts any command in flight and
  // returns every strobe to 0 without issuing a response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= OP_NOP;
      col_q         <= '0;
      mask_q        <= '0;
      retry_q       <= '0;
      cmd_ready_q   <= 1'b1;
      pl_q          <= '0;
      bl_q          <= '0;
      wln_q         <= '0;
      wlp_q         <= '0;
      prg_q         <= 1'b0;
      read_active_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_status_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      col_q         <= col_d;
      mask_q        <= mask_d;
      retry_q       <= retry_d;
      cmd_ready_q   <= cmd_ready_d;
      pl_q          <= pl_d;
      bl_q          <= bl_d;
      wln_q         <= wln_d;
      wlp_q         <= wlp_d;
      prg_q         <= prg_d;
      read_active_q <= read_active_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_status_q  <= rsp_status_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign pl          = pl_q;
  assign bl          = bl_q;
  assign wln         = wln_q;
  assign wlp         = wlp_q;
  assign prg         = prg_q;
  assign read_active = read_active_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_status  = rsp_status_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_otp_pgm_verify_ctrl.sv
// ---------------------------------------------------------------------------
// tb_otp_pgm_verify_ctrl
// Bench for the OTP program/verify controller. A behavioural fuse macro
// answers the sense window and burns bits under the HV strobe (with optional
// stuck bits); a command-level model predicts latency, pulses, data and
// status. A second instance with 12 columns exercises out-of-range columns.
// ---------------------------------------------------------------------------
module tb_otp_pgm_verify_ctrl;

  localparam int ROWS    = 8;
  localparam int COLS    = 16;
  localparam int P       = 10;
  localparam int S       = 4;
  localparam int MR      = 3;
  localparam int NB_COLS = 12;
  localparam int AW      = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              nb_valid;
  logic [1:0]        cmd_op;
  logic [AW-1:0]     cmd_col;
  logic [ROWS-1:0]   cmd_data;
  logic [ROWS-1:0]   sense_data;

  logic              cmd_ready, prg, read_active, rsp_valid, busy;
  logic [2*COLS-1:0] pl;
  logic [COLS-1:0]   bl;
  logic [ROWS-1:0]   wln, wlp, rsp_data;
  logic [1:0]        rsp_status;

  logic                 nb_cmd_ready, nb_prg, nb_read_active, nb_rsp_valid, nb_busy;
  logic [2*NB_COLS-1:0] nb_pl;
  logic [NB_COLS-1:0]   nb_bl;
  logic [ROWS-1:0]      nb_wln, nb_wlp, nb_rsp_data;
  logic [1:0]           nb_rsp_status;

  otp_pgm_verify_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .PGM_PULSE_CYC(P), .READ_SETTLE_CYC(S), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_col(cmd_col), .cmd_data(cmd_data), .sense_data(sense_data),
    .pl(pl), .bl(bl), .wln(wln), .wlp(wlp), .prg(prg), .read_active(read_active),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status), .busy(busy)
  );

  otp_pgm_verify_ctrl #(
    .ROWS(ROWS), .COLS(NB_COLS), .PGM_PULSE_CYC(P), .READ_SETTLE_CYC(S), .MAX_RETRY(MR)
  ) dut_nb (
    .clk(clk), .reset(reset), .cmd_valid(nb_valid), .cmd_ready(nb_cmd_ready),
    .cmd_op(cmd_op), .cmd_col(cmd_col), .cmd_data(cmd_data), .sense_data(sense_data),
    .pl(nb_pl), .bl(nb_bl), .wln(nb_wln), .wlp(nb_wlp), .prg(nb_prg),
    .read_active(nb_read_active), .rsp_valid(nb_rsp_valid), .rsp_data(nb_rsp_data),
    .rsp_status(nb_rsp_status), .busy(nb_busy)
  );

  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  // Fuse macro state and per-command observation
  logic [ROWS-1:0] fuse  [COLS];
  logic [ROWS-1:0] stuck [COLS];
  logic [ROWS-1:0] exp_pulses [$];
  logic [ROWS-1:0] obs_pulses [$];
  logic [ROWS-1:0] prev_wlp = '0;
  logic [ROWS-1:0] cur_data = '0;
  int cur_col = 0;
  int wlp_cycles, hv_cycles, pre_cycles, bl_cycles;

  // One clock: sample just after the edge, let the macro burn/sense, track
  // pulses and check the strobe invariants for the main instance.
  task automatic cycle();
    logic [ROWS-1:0]   sv;
    logic [COLS-1:0]   oh;
    logic [2*COLS-1:0] pm;
    @(posedge clk);
    #1;
    for (int c = 0; c < COLS; c++)
      if (prg === 1'b1 && pl[2*c+1] === 1'b1) fuse[c] = fuse[c] | (wlp & ~stuck[c]);
    if (wlp != '0 && prev_wlp == '0) obs_pulses.push_back(wlp);
    prev_wlp = wlp;
    if (wlp != '0) wlp_cycles++;
    if (pl != '0 && wlp == '0) pre_cycles++;
    if (pl[2*cur_col+1] === 1'b1) hv_cycles++;
    if (bl != '0) bl_cycles++;
    sv = ROWS'($urandom);
    if (read_active === 1'b1)
      for (int c = 0; c < COLS; c++) if (bl[c] === 1'b1) sv = fuse[c];
    sense_data = sv;
    oh = '0; oh[cur_col] = 1'b1;
    pm = '0; pm[2*cur_col] = 1'b1; pm[2*cur_col+1] = 1'b1;
    nvec++;
    if (bl != '0 && pl != '0) begin
      nfail++; $display("[TB] FAIL inv_bl_pl: bl=%h pl=%h, required not both nonzero", bl, pl);
    end
    nvec++;
    if (wln != '0 && wlp != '0) begin
      nfail++; $display("[TB] FAIL inv_wln_wlp: wln=%h wlp=%h, required not both nonzero", wln, wlp);
    end
    nvec++;
    if ((bl & ~oh) != '0 || (pl & ~pm) != '0) begin
      nfail++; $display("[TB] FAIL inv_column: bl=%h pl=%h, required only column %0d", bl, pl, cur_col);
    end
    nvec++;
    if ((wlp & ~cur_data) != '0) begin
      nfail++; $display("[TB] FAIL inv_wlp_subset: wlp=%h, required subset of %h", wlp, cur_data);
    end
    nvec++;
    if (prg !== (pl != '0) || busy !== ~cmd_ready) begin
      nfail++; $display("[TB] FAIL inv_prg_busy: prg=%b pl=%h busy=%b ready=%b, required prg==(pl!=0) busy==!ready",
                        prg, pl, busy, cmd_ready);
    end
  endtask

  // Command-level reference: latency, status, data and the sequence of
  // pulse masks, derived from the fuse contents at issue time.
  task automatic predict(input logic [1:0] op, input int col, input logic [ROWS-1:0] d,
                         output int lat, output logic [1:0] st, output logic [ROWS-1:0] rd);
    logic [ROWS-1:0] f, m, rem;
    int tries;
    exp_pulses.delete();
    lat = S + 1; st = 2'b00; rd = '0;
    f = fuse[col];
    case (op)
      2'b01: rd = f;
      2'b11: begin rd = f; if (f != '0) st = 2'b10; end
      2'b10: begin
        m = d & ~f; tries = 0;
        while (m != '0) begin
          exp_pulses.push_back(m);
          f = f | (m & ~stuck[col]);
          tries++;
          lat += P + S + 2;
          rem = m & ~f;
          if (rem == '0) m = '0;
          else if (tries > MR) begin st = 2'b01; m = '0; end
          else m = rem;
        end
        rd = f;
      end
      default: lat = 0;
    endcase
  endtask

  // Issue one command to the main instance and check its whole response.
  task automatic run_cmd(input logic [1:0] op, input int col, input logic [ROWS-1:0] d,
                         input bit junk, input string tag);
    int lat, exp_lat, w, np;
    logic [1:0] exp_st;
    logic [ROWS-1:0] exp_rd;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin cycle(); w++; end
    nvec++;
    if (cmd_ready !== 1'b1) begin
      nfail++; $display("[TB] FAIL %s_ready: cmd_ready=%b, required 1", tag, cmd_ready);
    end
    predict(op, col, d, exp_lat, exp_st, exp_rd);
    np = exp_pulses.size();
    cur_col = col; cur_data = d;
    obs_pulses.delete();
    wlp_cycles = 0; hv_cycles = 0; pre_cycles = 0; bl_cycles = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_col = AW'(col); cmd_data = d;
    cycle();
    cmd_valid = 1'b0;
    lat = 1;
    if (op == 2'b00) begin
      for (int i = 0; i < S + 3; i++) begin
        nvec++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
          nfail++; $display("[TB] FAIL %s_nop: rsp_valid=%b ready=%b, required 0/1", tag, rsp_valid, cmd_ready);
        end
        cycle();
      end
      return;
    end
    while (rsp_valid !== 1'b1 && lat < 400) begin
      if (junk) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op = 2'($urandom); cmd_col = AW'($urandom); cmd_data = ROWS'($urandom);
      end
      cycle(); lat++;
    end
    cmd_valid = 1'b0;
    nvec++;
    if (lat != exp_lat || rsp_valid !== 1'b1) begin
      nfail++; $display("[TB] FAIL %s_latency: got %0d cycles, required %0d", tag, lat, exp_lat);
    end
    nvec++;
    if (rsp_status !== exp_st) begin
      nfail++; $display("[TB] FAIL %s_status: got %b, required %b", tag, rsp_status, exp_st);
    end
    nvec++;
    if (rsp_data !== exp_rd) begin
      nfail++; $display("[TB] FAIL %s_data: got %h, required %h", tag, rsp_data, exp_rd);
    end
    nvec++;
    if (obs_pulses.size() != np) begin
      nfail++; $display("[TB] FAIL %s_pulses: got %0d pulses, required %0d", tag, obs_pulses.size(), np);
    end
    for (int i = 0; i < np && i < obs_pulses.size(); i++) begin
      nvec++;
      if (obs_pulses[i] !== exp_pulses[i]) begin
        nfail++; $display("[TB] FAIL %s_pulse%0d: wlp=%h, required %h", tag, i, obs_pulses[i], exp_pulses[i]);
      end
    end
    nvec++;
    if (wlp_cycles != np * P || hv_cycles != np * P || pre_cycles != np || bl_cycles != S * (1 + np)) begin
      nfail++;
      $display("[TB] FAIL %s_strobe_len: wlp=%0d hv=%0d pre=%0d bl=%0d, required %0d %0d %0d %0d",
               tag, wlp_cycles, hv_cycles, pre_cycles, bl_cycles, np * P, np * P, np, S * (1 + np));
    end
    cycle();
    nvec++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      nfail++; $display("[TB] FAIL %s_after: rsp_valid=%b ready=%b, required 0/1", tag, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; nb_valid = 1'b0;
    cmd_op = '0; cmd_col = '0; cmd_data = '0; sense_data = '0;
    cycle(); cycle();
    reset = 1'b0;
    nvec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || prg !== 1'b0 ||
        read_active !== 1'b0 || pl !== '0 || bl !== '0 || wln !== '0 || wlp !== '0 ||
        rsp_data !== '0 || rsp_status !== '0) begin
      nfail++;
      $display("[TB] FAIL reset_state: ready=%b busy=%b rv=%b prg=%b ra=%b pl=%h bl=%h wln=%h wlp=%h rd=%h rs=%b, required ready=1 rest 0",
               cmd_ready, busy, rsp_valid, prg, read_active, pl, bl, wln, wlp, rsp_data, rsp_status);
    end
  endtask

  task automatic test_read();
    fuse[5] = 8'hA5;
    run_cmd(2'b01, 5, 8'h00, 1'b0, "read");
  endtask

  task automatic test_program();
    fuse[3] = 8'h00;
    run_cmd(2'b10, 3, 8'h0F, 1'b0, "pgm_basic");
    run_cmd(2'b10, 3, 8'hFF, 1'b0, "pgm_partial");
    run_cmd(2'b10, 3, 8'hFF, 1'b0, "pgm_idempotent");
  endtask

  task automatic test_stuck();
    fuse[7] = 8'h00; stuck[7] = 8'h08;
    run_cmd(2'b10, 7, 8'h0F, 1'b0, "pgm_stuck");
  endtask

  task automatic test_blank_nop();
    fuse[0] = 8'h10; fuse[1] = 8'h00;
    run_cmd(2'b11, 0, 8'h00, 1'b0, "blank_set");
    run_cmd(2'b11, 1, 8'h00, 1'b0, "blank_clear");
    run_cmd(2'b00, 2, 8'hFF, 1'b0, "nop");
  endtask

  // Out-of-range columns on the 12-column instance, plus its last valid one.
  task automatic test_bad_col();
    logic [1:0] ops [3] = '{2'b01, 2'b10, 2'b11};
    int cols [3] = '{12, 15, 13};
    int lat;
    for (int i = 0; i < 3; i++) begin
      nb_valid = 1'b1; cmd_op = ops[i]; cmd_col = AW'(cols[i]); cmd_data = 8'hFF;
      cycle();
      nb_valid = 1'b0;
      nvec++;
      if (nb_rsp_valid !== 1'b1 || nb_rsp_status !== 2'b11 || nb_rsp_data !== '0) begin
        nfail++; $display("[TB] FAIL bad_col%0d_rsp: rv=%b st=%b data=%h, required 1/11/00",
                          cols[i], nb_rsp_valid, nb_rsp_status, nb_rsp_data);
      end
      nvec++;
      if (nb_pl !== '0 || nb_bl !== '0 || nb_wln !== '0 || nb_wlp !== '0 || nb_prg !== 1'b0 ||
          nb_read_active !== 1'b0) begin
        nfail++; $display("[TB] FAIL bad_col%0d_strobes: pl=%h bl=%h wln=%h wlp=%h prg=%b, required 0",
                          cols[i], nb_pl, nb_bl, nb_wln, nb_wlp, nb_prg);
      end
      cycle();
      nvec++;
      if (nb_rsp_valid !== 1'b0 || nb_cmd_ready !== 1'b1) begin
        nfail++; $display("[TB] FAIL bad_col%0d_after: rv=%b ready=%b, required 0/1",
                          cols[i], nb_rsp_valid, nb_cmd_ready);
      end
    end
    nb_valid = 1'b1; cmd_op = 2'b01; cmd_col = AW'(11);
    cycle();
    nb_valid = 1'b0; lat = 1;
    while (nb_rsp_valid !== 1'b1 && lat < 50) begin cycle(); lat++; end
    nvec++;
    if (lat != S + 1 || nb_rsp_status !== 2'b00) begin
      nfail++; $display("[TB] FAIL last_col: latency=%0d status=%b, required %0d/00", lat, nb_rsp_status, S + 1);
    end
    cycle();
  endtask

  task automatic test_reset_mid_pulse();
    int w;
    fuse[9] = '0; stuck[9] = '0;
    cur_col = 9; cur_data = 8'h3C;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_col = AW'(9); cmd_data = 8'h3C;
    cycle();
    cmd_valid = 1'b0;
    w = 0;
    while (wlp == '0 && w < 50) begin cycle(); w++; end
    repeat (3) cycle();
    nvec++;
    if (wlp !== 8'h3C || prg !== 1'b1) begin
      nfail++; $display("[TB] FAIL midrst_inpulse: wlp=%h prg=%b, required 3c/1", wlp, prg);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    nvec++;
    if (prg !== 1'b0 || pl !== '0 || wlp !== '0 || bl !== '0 || cmd_ready !== 1'b1 ||
        rsp_valid !== 1'b0 || busy !== 1'b0) begin
      nfail++; $display("[TB] FAIL midrst_abort: prg=%b pl=%h wlp=%h bl=%h ready=%b rv=%b busy=%b, required idle",
                        prg, pl, wlp, bl, cmd_ready, rsp_valid, busy);
    end
    for (int i = 0; i < 2 * P; i++) begin
      cycle();
      nvec++;
      if (rsp_valid !== 1'b0) begin
        nfail++; $display("[TB] FAIL midrst_no_rsp: rsp_valid=%b, required 0", rsp_valid);
      end
    end
    run_cmd(2'b01, 9, 8'h00, 1'b0, "midrst_read");
  endtask

  task automatic test_random();
    for (int c = 0; c < COLS; c++) begin
      fuse[c]  = ROWS'($urandom) & ROWS'($urandom);
      stuck[c] = ($urandom_range(0, 3) == 0) ? ROWS'(1 << $urandom_range(0, ROWS - 1)) : '0;
    end
    for (int n = 0; n < 40; n++) begin
      run_cmd(2'($urandom), $urandom_range(0, COLS - 1), ROWS'($urandom), 1'b1, "rand");
      repeat ($urandom_range(0, 2)) cycle();
    end
  endtask

  initial begin
    for (int c = 0; c < COLS; c++) begin fuse[c] = '0; stuck[c] = '0; end
    test_reset();
    test_read();
    test_program();
    test_stuck();
    test_blank_nop();
    test_bad_col();
    test_reset_mid_pulse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
